// File: rtl/imem_responder_pkg.sv
// Shared widths, FSM state type and response data pattern for the instruction memory responder.
package imem_responder_pkg;

  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 32;
  localparam int WORD_LSB   = 2;
  localparam int CNT_W      = 8;
  localparam int RESP_CNT_W = 20;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    MISS,
    RESP
  } state_t;

  // Only the word address matters, so the byte-offset bits never reach this function.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:WORD_LSB] a);
    return {~a[18:14], a[5:2], ~a[9:7], a[13:10], a[8:6], ~a[13:10], a[23:19], ~a[5:2]};
  endfunction

endpackage

// File: rtl/imem_responder_req_fifo.sv
// Request address FIFO for imem_responder; push/pop are ignored when full/empty respectively.
module imem_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory responder: queues fetch addresses, models a one-line tag with miss latency.
// Optional macro ICACHE_ERR_INJECT_EN corrupts bit 0 of response number ERR_INDEX.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int                    MISS_LAT   = 8,
  parameter int                    LINE_BITS  = 5,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [RESP_CNT_W-1:0] ERR_INDEX  = 20'd100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              ready_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ready_in
);

  localparam int TAG_W = ADDR_W - LINE_BITS;

  state_t                      state;
  state_t                      next_state;
  logic [ADDR_W-1:WORD_LSB]    addr_reg;
  logic [ADDR_W-1:WORD_LSB]    fifo_head;
  logic [TAG_W-1:0]            tag;
  logic                        tag_valid;
  logic [CNT_W-1:0]            miss_cnt;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        push;
  logic                        pop;
  logic                        hit;
  logic                        err_flip;
  logic                        addr_lsb_unused;

  assign addr_lsb_unused = ^addr_in[1:0];
  assign ready_out = ~fifo_full;
  assign push      = valid_in & ~fifo_full;
  assign pop       = ((state == IDLE) || (state == RESP && ready_in)) && !fifo_empty;
  assign hit       = tag_valid && (tag == addr_reg[ADDR_W-1:LINE_BITS]);

  imem_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W - WORD_LSB)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (addr_in[ADDR_W-1:WORD_LSB]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!fifo_empty) next_state = CHECK;
      CHECK:   next_state = hit ? RESP : MISS;
      MISS:    if (miss_cnt == CNT_W'(1)) next_state = RESP;
      RESP:    if (ready_in) next_state = fifo_empty ? IDLE : CHECK;
      default: next_state = IDLE;
    endcase
  end

  // The tag is only filled when the miss wait completes, so a reset mid-miss leaves it invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg  <= '0;
      tag       <= '0;
      tag_valid <= 1'b0;
      miss_cnt  <= '0;
    end else begin
      if (pop) addr_reg <= fifo_head;
      if (state == CHECK && !hit) miss_cnt <= CNT_W'(MISS_LAT);
      if (state == MISS) begin
        miss_cnt <= miss_cnt - CNT_W'(1);
        if (miss_cnt == CNT_W'(1)) begin
          tag       <= addr_reg[ADDR_W-1:LINE_BITS];
          tag_valid <= 1'b1;
        end
      end
    end
  end

`ifdef ICACHE_ERR_INJECT_EN
  logic [RESP_CNT_W-1:0] resp_cnt;

  always_ff @(posedge clk) begin
    if (rst)                         resp_cnt <= '0;
    else if (valid_out && ready_in)  resp_cnt <= resp_cnt + RESP_CNT_W'(1);
  end

  assign err_flip = (resp_cnt == ERR_INDEX);
`else
  localparam logic [RESP_CNT_W-1:0] ERR_INDEX_UNUSED = ERR_INDEX;
  assign err_flip = 1'b0;
`endif

  always_comb begin
    valid_out = 1'b0;
    data_out  = '0;
    if (state == RESP) begin
      valid_out = 1'b1;
      data_out  = pattern(addr_reg) ^ {{(DATA_W-1){1'b0}}, err_flip};
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: latency, ordering, backpressure, reset and random traffic.
module tb_imem_responder;

  localparam int MISS_LAT = 8;
  localparam int ERR_IDX  = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [23:0] addr_in;
  logic        ready_out;
  logic        valid_out;
  logic [31:0] data_out;
  logic        ready_in;

  logic [31:0] sb [$];
  int          total = 0;
  int          bad = 0;
  int          resp_idx = 0;
  logic        held_v = 1'b0;
  logic [31:0] held;
  logic        model_valid = 1'b0;
  logic [18:0] model_tag = '0;

  imem_responder #(
    .MISS_LAT   (MISS_LAT),
    .LINE_BITS  (5),
    .FIFO_DEPTH (4),
    .ERR_INDEX  (20'd100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .addr_in   (addr_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_in  (ready_in)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fexp(input logic [23:0] a);
    return {~a[18:14], a[5:2], ~a[9:7], a[13:10], a[8:6], ~a[13:10], a[23:19], ~a[5:2]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Sampled mid-low-phase: a response seen valid with ready_in high transfers at the next edge.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        sb.delete();
        resp_idx = 0;
        held_v   = 1'b0;
      end else begin
        if (held_v && valid_out) checkOutput("hold", data_out, held);
        if (valid_out && ready_in) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_resp", 32'(valid_out), 32'd0);
          end else begin
            exp = sb.pop_front();
`ifdef ICACHE_ERR_INJECT_EN
            if (resp_idx == ERR_IDX) exp[0] = ~exp[0];
`endif
            checkOutput("resp_data", data_out, exp);
          end
          resp_idx++;
        end
        held_v = valid_out && !ready_in;
        held   = data_out;
      end
    end
  end

  task automatic applyStimulus(input logic [23:0] a, input logic [31:0] exp_data, input string tag);
    int k;
    int exp_lat;
    exp_lat = (model_valid && model_tag == a[23:5]) ? 2 : 2 + MISS_LAT;
    model_valid = 1'b1;
    model_tag   = a[23:5];
    @(negedge clk);
    checkOutput({tag, "_rdy"}, 32'(ready_out), 32'd1);
    valid_in = 1'b1;
    addr_in  = a;
    ready_in = 1'b1;
    sb.push_back(exp_data);
    @(negedge clk);
    valid_in = 1'b0;
    k = 0;
    while (!valid_out && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_lat"}, 32'(k), 32'(exp_lat));
    @(negedge clk);
  endtask

  initial begin
    int acc;
    int k;
    int sent;
    int cyc;
    int n_rand;
    logic seen;
    logic [23:0] a;

    rst = 1'b1; valid_in = 1'b0; addr_in = '0; ready_in = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(valid_out), 32'd0);
    checkOutput("rst_data", data_out, 32'd0);
    checkOutput("rst_ready", 32'(ready_out), 32'd1);
    rst = 1'b0;

    applyStimulus(24'h000000, 32'hF8701E0F, "first_miss");
    applyStimulus(24'h000004, 32'hF8F01E0E, "same_line_hit");

    applyStimulus(24'h010000, fexp(24'h010000), "alt0");
    applyStimulus(24'h020000, fexp(24'h020000), "alt1");
    applyStimulus(24'h010000, fexp(24'h010000), "alt2");
    applyStimulus(24'h020000, fexp(24'h020000), "alt3");
    applyStimulus(24'h010000, fexp(24'h010000), "alt4");
    applyStimulus(24'h010000, fexp(24'h010000), "rep_hit");
    applyStimulus(24'h010004, fexp(24'h010004), "rep_hit2");
    applyStimulus(24'hFFFFFC, fexp(24'hFFFFFC), "wrap_top");
    applyStimulus(24'h000000, fexp(24'h000000), "wrap_zero");

    // Backpressure: one request held in RESP plus four queued fills the responder.
    ready_in = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 24'h000100 + 24'(4 * i);
      valid_in = 1'b1;
      addr_in  = a;
      if (ready_out) begin
        sb.push_back(fexp(a));
        acc++;
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    checkOutput("bp_accepted", 32'(acc), 32'd5);
    checkOutput("bp_full", 32'(ready_out), 32'd0);
    model_valid = 1'b1;
    model_tag   = 19'(24'h000100 >> 5);
    k = 0;
    while (!valid_out && k < 50) begin
      @(negedge clk);
      k++;
    end
    ready_in = 1'b1;
    #3;
    k = 0;
    while (sb.size() > 0 && k < 50) begin
      @(negedge clk);
      #3;
      k++;
    end
    checkOutput("bp_throughput", 32'(k), 32'd8);
    @(negedge clk);

    // Reset while the first of four requests is waiting out its miss.
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 24'h300000 + 24'(32 * i);
      valid_in = 1'b1;
      addr_in  = a;
      sb.push_back(fexp(a));
    end
    @(negedge clk);
    valid_in = 1'b0;
    checkOutput("rm_in_miss", 32'(valid_out), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rm_valid", 32'(valid_out), 32'd0);
    checkOutput("rm_empty", 32'(ready_out), 32'd1);
    rst = 1'b0;
    model_valid = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (valid_out) seen = 1'b1;
    end
    checkOutput("rm_stale", 32'(seen), 32'd0);
    applyStimulus(24'h000000, fexp(24'h000000), "post_rst_miss");

    // Random traffic over a handful of lines with random backpressure.
`ifdef ICACHE_ERR_INJECT_EN
    n_rand = 1000;
`else
    n_rand = 300;
`endif
    sent = 0;
    cyc  = 0;
    while (sent < n_rand && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      a = 24'h400000 | 24'($urandom_range(0, 7) << 5) | 24'($urandom_range(0, 7) << 2);
      valid_in = 1'($urandom_range(0, 1));
      addr_in  = a;
      ready_in = ($urandom_range(0, 3) != 0);
      if (valid_in && ready_out) begin
        sb.push_back(fexp(a));
        sent++;
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    ready_in = 1'b1;
    checkOutput("rand_sent", 32'(sent), 32'(n_rand));
    k = 0;
    while (sb.size() > 0 && k < 4000) begin
      @(negedge clk);
      #3;
      k++;
    end
    checkOutput("rand_drain", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("final_idle", 32'(valid_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
